// File: rtl/mipi_stream_extractor.sv
// rtl/mipi_stream_extractor.sv - CSI-2 byte stream parser: filters one VC/DT and packs payload bytes into output words
module mipi_stream_extractor #(
  parameter int         OUT_BYTES = 2,
  parameter int         VC_SEL    = 0,
  parameter logic [7:0] DT_SEL    = 8'h2C,
  parameter int         EXP_WC    = 1280,
  parameter int         MAX_LINES = 1023,
  localparam int        LCW       = $clog2(MAX_LINES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             mipi_data,
  input  logic                   mipi_data_valid,
  input  logic                   enable,
  output logic [8*OUT_BYTES-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   m_sof,
  output logic                   frame_start,
  output logic                   line_done,
  output logic                   frame_done,
  output logic [15:0]            frame_number,
  output logic [LCW-1:0]         line_count,
  output logic                   err_wc,
  output logic                   err_short,
  output logic                   err_overflow
);

  localparam int             W         = 8 * OUT_BYTES;
  localparam logic [1:0]     LAST_LANE = 2'(OUT_BYTES - 1);
  localparam logic [LCW-1:0] LC_MAX    = LCW'(MAX_LINES);

  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_HDR, S_PAYLOAD, S_SKIP} state_t;

  state_t         state_q, state_d;
  logic [1:0]     hdr_cnt_q, hdr_cnt_d;
  logic [7:0]     di_q, di_d;
  logic [15:0]    wc_q, wc_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [1:0]     lane_q, lane_d;
  logic [W-1:0]   acc_q, acc_d;
  logic           sof_arm_q, sof_arm_d;
  logic           held_cur_q, held_cur_d;
  logic [W-1:0]   m_data_q, m_data_d;
  logic           m_valid_q, m_valid_d;
  logic           m_last_q, m_last_d;
  logic           m_sof_q, m_sof_d;
  logic           frame_start_q, frame_start_d;
  logic           line_done_q, line_done_d;
  logic           frame_done_q, frame_done_d;
  logic [15:0]    frame_number_q, frame_number_d;
  logic [LCW-1:0] line_count_q, line_count_d;
  logic           err_wc_q, err_wc_d;
  logic           err_short_q, err_short_d;
  logic           err_overflow_q, err_overflow_d;

  logic [W-1:0]   word_w, load_word;
  logic           load, load_last, line_end, short_tag;

  // A short packet that ends exactly on a word boundary has no partial word to
  // flush, so the word still held from this packet is tagged as the line end.
  assign short_tag = (state_q == S_PAYLOAD) && !mipi_data_valid && (lane_q == 2'd0)
                     && held_cur_q && m_valid_q;

  always_comb begin
    state_d        = state_q;
    hdr_cnt_d      = hdr_cnt_q;
    di_d           = di_q;
    wc_d           = wc_q;
    cnt_d          = cnt_q;
    lane_d         = lane_q;
    acc_d          = acc_q;
    sof_arm_d      = sof_arm_q;
    held_cur_d     = held_cur_q;
    m_data_d       = m_data_q;
    m_valid_d      = m_valid_q;
    m_last_d       = m_last_q;
    m_sof_d        = m_sof_q;
    frame_start_d  = 1'b0;
    line_done_d    = 1'b0;
    frame_done_d   = 1'b0;
    frame_number_d = frame_number_q;
    line_count_d   = line_count_q;
    err_wc_d       = err_wc_q;
    err_short_d    = err_short_q;
    err_overflow_d = err_overflow_q;
    load           = 1'b0;
    load_word      = '0;
    load_last      = 1'b0;
    line_end       = 1'b0;

    for (int i = 0; i < OUT_BYTES; i++) begin
      word_w[8*i +: 8] = (lane_q == 2'(i)) ? mipi_data : acc_q[8*i +: 8];
    end

    case (state_q)
      S_SYNC: if (!mipi_data_valid) state_d = S_IDLE;
      S_IDLE: begin
        if (mipi_data_valid) begin
          if (enable) begin
            di_d       = mipi_data;
            hdr_cnt_d  = 2'd1;
            held_cur_d = 1'b0;
            state_d    = S_HDR;
          end else begin
            state_d = S_SKIP;
          end
        end
      end
      S_HDR: begin
        if (!mipi_data_valid) begin
          state_d = S_IDLE;
        end else begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          case (hdr_cnt_q)
            2'd1: wc_d[7:0]  = mipi_data;
            2'd2: wc_d[15:8] = mipi_data;
            default: begin
              // ECC byte: DI and WC are already registered, decide now.
              state_d = S_SKIP;
              if (di_q[7:6] == 2'(VC_SEL)) begin
                if (di_q[5:0] == 6'h00) begin
                  frame_start_d  = 1'b1;
                  frame_number_d = wc_q;
                  line_count_d   = '0;
                  sof_arm_d      = 1'b1;
                end else if (di_q[5:0] == 6'h01) begin
                  frame_done_d = 1'b1;
                end else if (di_q[5:0] == DT_SEL[5:0]) begin
                  if (wc_q != 16'(EXP_WC)) err_wc_d = 1'b1;
                  cnt_d  = '0;
                  lane_d = '0;
                  acc_d  = '0;
                  if (wc_q != 16'd0) state_d = S_PAYLOAD;
                end
              end
            end
          endcase
        end
      end
      S_PAYLOAD: begin
        if (mipi_data_valid) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == wc_q - 16'd1) begin
            load      = 1'b1;
            load_word = word_w;
            load_last = 1'b1;
            line_end  = 1'b1;
            acc_d     = '0;
            lane_d    = '0;
            state_d   = S_SKIP;
          end else if (lane_q == LAST_LANE) begin
            load      = 1'b1;
            load_word = word_w;
            acc_d     = '0;
            lane_d    = '0;
          end else begin
            acc_d  = word_w;
            lane_d = lane_q + 2'd1;
          end
        end else begin
          err_short_d = 1'b1;
          state_d     = S_IDLE;
          if (lane_q != 2'd0) begin
            load      = 1'b1;
            load_word = acc_q;
            load_last = 1'b1;
          end
        end
      end
      S_SKIP: if (!mipi_data_valid) state_d = S_IDLE;
      default: state_d = S_SYNC;
    endcase

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      m_sof_d   = 1'b0;
    end else if (short_tag) begin
      m_last_d = 1'b1;
    end

    if (load) begin
      if (!m_valid_q || m_ready) begin
        m_valid_d  = 1'b1;
        m_data_d   = load_word;
        m_last_d   = load_last;
        m_sof_d    = sof_arm_q;
        sof_arm_d  = 1'b0;
        held_cur_d = 1'b1;
      end else begin
        err_overflow_d = 1'b1;
      end
    end

    if (line_end) begin
      line_done_d = 1'b1;
      if (line_count_q != LC_MAX) line_count_d = line_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_SYNC;
      hdr_cnt_q      <= '0;
      di_q           <= '0;
      wc_q           <= '0;
      cnt_q          <= '0;
      lane_q         <= '0;
      acc_q          <= '0;
      sof_arm_q      <= 1'b0;
      held_cur_q     <= 1'b0;
      m_data_q       <= '0;
      m_valid_q      <= 1'b0;
      m_last_q       <= 1'b0;
      m_sof_q        <= 1'b0;
      frame_start_q  <= 1'b0;
      line_done_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_number_q <= '0;
      line_count_q   <= '0;
      err_wc_q       <= 1'b0;
      err_short_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hdr_cnt_q      <= hdr_cnt_d;
      di_q           <= di_d;
      wc_q           <= wc_d;
      cnt_q          <= cnt_d;
      lane_q         <= lane_d;
      acc_q          <= acc_d;
      sof_arm_q      <= sof_arm_d;
      held_cur_q     <= held_cur_d;
      m_data_q       <= m_data_d;
      m_valid_q      <= m_valid_d;
      m_last_q       <= m_last_d;
      m_sof_q        <= m_sof_d;
      frame_start_q  <= frame_start_d;
      line_done_q    <= line_done_d;
      frame_done_q   <= frame_done_d;
      frame_number_q <= frame_number_d;
      line_count_q   <= line_count_d;
      err_wc_q       <= err_wc_d;
      err_short_q    <= err_short_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign m_last       = m_last_q | short_tag;
  assign m_sof        = m_sof_q;
  assign frame_start  = frame_start_q;
  assign line_done    = line_done_q;
  assign frame_done   = frame_done_q;
  assign frame_number = frame_number_q;
  assign line_count   = line_count_q;
  assign err_wc       = err_wc_q;
  assign err_short    = err_short_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_mipi_stream_extractor.sv
// tb/tb_mipi_stream_extractor.sv - scoreboard bench for mipi_stream_extractor, 2-byte and 4-byte instances
module tb_mipi_stream_extractor;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mipi_data;
  logic        mipi_data_valid;
  logic        enable;
  logic        m_ready2, m_ready4;

  logic [15:0] m_data2;
  logic        m_valid2, m_last2, m_sof2, frame_start2, line_done2, frame_done2;
  logic [15:0] frame_number2;
  logic [9:0]  line_count2;
  logic        err_wc2, err_short2, err_overflow2;

  logic [31:0] m_data4;
  logic        m_valid4, m_last4, m_sof4, frame_start4, line_done4, frame_done4;
  logic [15:0] frame_number4;
  logic [1:0]  line_count4;
  logic        err_wc4, err_short4, err_overflow4;

  always #5 clk = ~clk;

  mipi_stream_extractor #(.OUT_BYTES(2)) dut2 (
    .clk(clk), .rst(rst), .mipi_data(mipi_data), .mipi_data_valid(mipi_data_valid),
    .enable(enable), .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2),
    .m_last(m_last2), .m_sof(m_sof2), .frame_start(frame_start2), .line_done(line_done2),
    .frame_done(frame_done2), .frame_number(frame_number2), .line_count(line_count2),
    .err_wc(err_wc2), .err_short(err_short2), .err_overflow(err_overflow2)
  );

  mipi_stream_extractor #(.OUT_BYTES(4), .MAX_LINES(3)) dut4 (
    .clk(clk), .rst(rst), .mipi_data(mipi_data), .mipi_data_valid(mipi_data_valid),
    .enable(enable), .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready4),
    .m_last(m_last4), .m_sof(m_sof4), .frame_start(frame_start4), .line_done(line_done4),
    .frame_done(frame_done4), .frame_number(frame_number4), .line_count(line_count4),
    .err_wc(err_wc4), .err_short(err_short4), .err_overflow(err_overflow4)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        sof;
  } exp_t;

  exp_t q2[$];
  exp_t q4[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   fs_cnt = 0, ld_cnt = 0, fd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_start2) fs_cnt++;
      if (line_done2)   ld_cnt++;
      if (frame_done2)  fd_cnt++;
      if (m_valid2 && m_ready2) begin
        if (q2.size() == 0) begin
          chk("unexpected_word2", 32'(m_valid2), 32'd0);
        end else begin
          exp_t e;
          e = q2.pop_front();
          chk("data2", 32'(m_data2), e.data);
          chk("last2", 32'(m_last2), 32'(e.last));
          chk("sof2",  32'(m_sof2),  32'(e.sof));
        end
      end
      if (m_valid4 && m_ready4) begin
        if (q4.size() == 0) begin
          chk("unexpected_word4", 32'(m_valid4), 32'd0);
        end else begin
          exp_t e;
          e = q4.pop_front();
          chk("data4", m_data4, e.data);
          chk("last4", 32'(m_last4), 32'(e.last));
          chk("sof4",  32'(m_sof4),  32'(e.sof));
        end
      end
    end
  end

  // Payload byte k is always k mod 256; pack n bytes for both word widths.
  task automatic exp_words(input int n, input bit sof, input bit last);
    exp_t e;
    int   nw;
    for (int ob = 2; ob <= 4; ob += 2) begin
      nw = last ? (n + ob - 1) / ob : n / ob;
      for (int w = 0; w < nw; w++) begin
        e.data = '0;
        for (int j = 0; j < ob; j++) begin
          if (w * ob + j < n) e.data[8*j +: 8] = 8'((w * ob + j) % 256);
        end
        e.last = last && (w == nw - 1);
        e.sof  = sof && (w == 0);
        if (ob == 2) q2.push_back(e);
        else         q4.push_back(e);
      end
    end
  endtask

  task automatic put_byte(input logic [7:0] b);
    mipi_data       = b;
    mipi_data_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    mipi_data_valid = 1'b0;
    mipi_data       = 8'h00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    put_byte(b0);
    put_byte(b1);
    put_byte(b2);
    put_byte(b3);
  endtask

  task automatic send_line(input logic [7:0] di, input int n);
    send_hdr(di, 8'h00, 8'h05, 8'h13);
    for (int k = 0; k < n; k++) put_byte(8'(k % 256));
    put_byte(8'hA5);
    put_byte(8'h5A);
    gap(4);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q2.size() != 0 || q4.size() != 0); i++) @(posedge clk);
    #1;
    chk("drain_pending", 32'(q2.size() + q4.size()), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    enable          = 1'b1;
    m_ready2        = 1'b1;
    m_ready4        = 1'b1;
    mipi_data       = 8'h00;
    mipi_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'({m_valid2, m_valid4, m_last2, m_sof2}), 32'd0);
    chk("rst_m_data", 32'(m_data2), 32'd0);
    chk("rst_line_count", 32'(line_count2), 32'd0);
    chk("rst_frame_number", 32'(frame_number2), 32'd0);
    chk("rst_errors", 32'({err_wc2, err_short2, err_overflow2}), 32'd0);
    rst = 1'b0;
    gap(3);

    // frame start
    send_hdr(8'h00, 8'h01, 8'h00, 8'h1A);
    gap(4);
    chk("fs_pulses", 32'(fs_cnt), 32'd1);
    chk("frame_number2", 32'(frame_number2), 32'd1);
    chk("frame_number4", 32'(frame_number4), 32'd1);

    // full line, first word carries sof
    exp_words(1280, 1'b1, 1'b1);
    send_line(8'h2C, 1280);
    drain();
    chk("line1_ld", 32'(ld_cnt), 32'd1);
    chk("line1_lc2", 32'(line_count2), 32'd1);
    chk("line1_lc4", 32'(line_count4), 32'd1);
    chk("line1_err_wc", 32'(err_wc2), 32'd0);

    // other virtual channel is ignored
    send_line(8'h6C, 1280);
    drain();
    chk("vc1_ld", 32'(ld_cnt), 32'd1);
    chk("vc1_errors", 32'({err_wc2, err_short2, err_overflow2, err_wc4, err_short4, err_overflow4}), 32'd0);

    // short line: valid drops after 100 payload bytes
    exp_words(100, 1'b0, 1'b1);
    send_hdr(8'h2C, 8'h00, 8'h05, 8'h13);
    for (int k = 0; k < 100; k++) put_byte(8'(k));
    gap(4);
    drain();
    chk("short_err2", 32'(err_short2), 32'd1);
    chk("short_err4", 32'(err_short4), 32'd1);
    chk("short_lc2", 32'(line_count2), 32'd1);
    chk("short_ld", 32'(ld_cnt), 32'd1);

    // next line parses normally
    exp_words(1280, 1'b0, 1'b1);
    send_line(8'h2C, 1280);
    drain();
    chk("line2_lc2", 32'(line_count2), 32'd2);
    chk("line2_ld", 32'(ld_cnt), 32'd2);

    // unexpected word count of 5
    exp_words(5, 1'b0, 1'b1);
    send_hdr(8'h2C, 8'h05, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) put_byte(8'(k));
    put_byte(8'hA5);
    put_byte(8'h5A);
    gap(4);
    drain();
    chk("wc5_err_wc2", 32'(err_wc2), 32'd1);
    chk("wc5_err_wc4", 32'(err_wc4), 32'd1);
    chk("wc5_lc4", 32'(line_count4), 32'd3);

    // sink stalled for a whole line: first word held, rest dropped
    m_ready2 = 1'b0;
    m_ready4 = 1'b0;
    q2.push_back('{data: 32'h0000_0100, last: 1'b0, sof: 1'b0});
    q4.push_back('{data: 32'h0302_0100, last: 1'b0, sof: 1'b0});
    send_line(8'h2C, 1280);
    chk("ovf_err2", 32'(err_overflow2), 32'd1);
    chk("ovf_err4", 32'(err_overflow4), 32'd1);
    chk("ovf_held", 32'({m_valid2, m_valid4}), 32'd3);
    chk("ovf_ld", 32'(ld_cnt), 32'd4);
    chk("ovf_lc2", 32'(line_count2), 32'd4);
    chk("ovf_lc4_sat", 32'(line_count4), 32'd3);
    m_ready2 = 1'b1;
    m_ready4 = 1'b1;
    drain();

    // reset in the middle of a payload with valid held high
    exp_words(32, 1'b0, 1'b0);
    send_hdr(8'h2C, 8'h00, 8'h05, 8'h13);
    for (int k = 0; k < 84; k++) begin
      rst = (k == 33);
      put_byte(8'(k));
    end
    rst = 1'b0;
    gap(4);
    drain();
    chk("rstmid_lc2", 32'(line_count2), 32'd0);
    chk("rstmid_errors", 32'({err_wc2, err_short2, err_overflow2}), 32'd0);
    chk("rstmid_valid", 32'({m_valid2, m_valid4}), 32'd0);
    exp_words(1280, 1'b0, 1'b1);
    send_line(8'h2C, 1280);
    drain();
    chk("after_rst_lc2", 32'(line_count2), 32'd1);
    chk("after_rst_ld", 32'(ld_cnt), 32'd5);

    // parse disabled: packet skipped
    enable = 1'b0;
    send_line(8'h2C, 1280);
    enable = 1'b1;
    drain();
    chk("disabled_ld", 32'(ld_cnt), 32'd5);

    // frame end
    send_hdr(8'h01, 8'h00, 8'h00, 8'h00);
    gap(4);
    chk("fe_pulses", 32'(fd_cnt), 32'd1);
    chk("fs_total", 32'(fs_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mipi_stream_extractor.md
MIPI_STREAM_EXTRACTOR -- requirements
Module: mipi_stream_extractor

Interface
REQ-001 Parameter OUT_BYTES, default 2: bytes packed per output word; legal values 1, 2, 4.
REQ-002 Parameter VC_SEL, default 0: virtual channel accepted; other VCs ignored.
REQ-003 Parameter DT_SEL, default 8'h2C: long-packet data type extracted as pixel payload.
REQ-004 Parameter EXP_WC, default 1280: expected long-packet word count, in bytes.
REQ-005 Parameter MAX_LINES, default 1023: width of line_count is clog2(MAX_LINES+1); the count saturates at MAX_LINES.
REQ-006 clk  in  1  single clock; all logic is on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 mipi_data  in  8  CSI-2 byte stream.
REQ-009 mipi_data_valid  in  1  byte qualifier; high for the whole packet, low between packets.
REQ-010 enable  in  1  parse enable, sampled only in IDLE.
REQ-011 m_data  out  8*OUT_BYTES  packed pixel bytes; first received byte in bits [7:0].
REQ-012 m_valid / m_ready  out / in  1 / 1  output handshake.
REQ-013 m_last  out  1  marks the final word of a line.
REQ-014 m_sof  out  1  marks the first word after a frame start.
REQ-015 frame_start, line_done, frame_done  out  1 each  single-cycle pulses.
REQ-016 frame_number  out  16  WC field of the last accepted FS packet.
REQ-017 line_count  out  clog2(MAX_LINES+1)  lines completed in the current frame.
REQ-018 err_wc, err_short, err_overflow  out  1 each  sticky error flags; cleared only by rst.

Function
REQ-019 States: SYNC, IDLE, HDR, PAYLOAD, SKIP.
  - SYNC: wait until mipi_data_valid is low, then go to IDLE.
  - IDLE: go to HDR when mipi_data_valid and enable are both high; that byte is header byte 0.
REQ-020 HDR captures 4 bytes: DI (VC=[7:6], DT=[5:0]), WC LSB, WC MSB, ECC; ECC is not checked.
REQ-021 Decision on the cycle after ECC is captured; every other case goes to SKIP:
  - VC != VC_SEL: SKIP.
  - DT=0x00 (FS): frame_start pulse, frame_number <= WC, line_count <= 0, arm m_sof.
  - DT=0x01 (FE): frame_done pulse.
  - DT=DT_SEL: go to PAYLOAD.
REQ-022 If a DT_SEL packet has WC != EXP_WC: set err_wc, still extract WC bytes.
REQ-023 PAYLOAD: accept exactly WC bytes.
  - Pack OUT_BYTES bytes per word.
  - The final partial word is zero-padded in its high bytes and carries m_last=1.
  - After the last payload byte go to SKIP; CRC and trailing bytes are discarded.
REQ-024 If mipi_data_valid falls in PAYLOAD before WC bytes are received:
  - set err_short;
  - flush the partial word with m_last=1;
  - no line_done pulse, no line_count increment;
  - go to IDLE.
REQ-025 SKIP: wait for mipi_data_valid low, then go to IDLE.
REQ-026 Line completion, on the cycle the m_last word is loaded:
  - line_done pulses for one cycle;
  - line_count increments, saturating at MAX_LINES.
REQ-027 Output register: m_valid is set when a word completes; the word is held until m_valid && m_ready.
REQ-028 Output latency: m_valid rises on the cycle after the last byte of a word is received.
REQ-029 Input cannot stall. If a word completes while m_valid && !m_ready:
  - the new word is dropped and err_overflow is set;
  - the held word is kept;
  - the line still counts if its final word completed.
REQ-030 m_sof is set on the first payload word after FS and cleared once that word is transferred.
REQ-031 Completion and transfer on the same cycle: the new word replaces the old one and m_valid stays high.
REQ-032 enable low in IDLE: packets are not parsed and the block goes to SKIP.

Reset
REQ-033 On rst:
  - state <= SYNC;
  - m_valid, m_last, m_sof, all pulses, and all error flags <= 0;
  - line_count <= 0, frame_number <= 0, m_data <= 0.
REQ-034 Reset asserted mid-packet: the remainder of that packet is discarded via SYNC; no partial word is emitted.

Verification
REQ-035 FS 00 01 00 1A, gap, then line 2C 00 05 13 with bytes 0..255 repeating, 1280 bytes + 2 CRC, m_ready=1, OUT_BYTES=2:
  - frame_start pulses, frame_number=1;
  - 640 words, first m_data=16'h0100 with m_sof=1;
  - last word m_last=1;
  - line_done pulses once, line_count=1.
REQ-036 WC=5 (2C 05 00 xx), OUT_BYTES=4: two words; the second is 32'h000000_04 with m_last=1; err_wc=1.
REQ-037 mipi_data_valid dropped after 100 payload bytes:
  - err_short=1, m_last on word 50;
  - line_count unchanged;
  - the next packet is parsed normally.
REQ-038 m_ready held low for a full line: the first word is held, err_overflow=1, line_done still pulses.
REQ-039 VC=1 packet (DI=8'h6C) with VC_SEL=0: no output, no pulses, no error flags.
REQ-040 rst mid-payload, then valid stays high for 50 more bytes: no output until the next header after a valid-low gap.
